// File: rtl/spi_controller.sv
// SPI mode-0 initiator: MSB first, one byte per accepted start, CS_N held across bytes until 'last'.
// Define SPI_MISO_SYNC_EN to pass MISO through a 2-flop synchronizer (requires HALF_PERIOD >= 3).
module spi_controller #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       last,
  output logic       ready,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int unsigned CntW = $clog2(HALF_PERIOD + 1);
  localparam logic [CntW-1:0] HpLast = CntW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {StIdle, StLead, StXfer, StTrail, StGap} state_e;

  state_e          state_q;
  logic [CntW-1:0] hp_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      tx_sr_q;
  logic [7:0]      rx_sr_q;
  logic            last_q;
  logic            miso_s;
  logic            accept;
  logic            hp_end;

  if (HALF_PERIOD < 1) begin : g_hp_chk
    $error("spi_controller: HALF_PERIOD must be >= 1");
  end

`ifdef SPI_MISO_SYNC_EN
  if (HALF_PERIOD < 3) begin : g_sync_chk
    $error("spi_controller: HALF_PERIOD must be >= 3 with SPI_MISO_SYNC_EN");
  end

  localparam bit SampleOnFall = 1'b1;
  logic [1:0] miso_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_sync_q <= 2'b00;
    end else begin
      miso_sync_q <= {miso_sync_q[0], spi_miso};
    end
  end

  assign miso_s = miso_sync_q[1];
`else
  localparam bit SampleOnFall = 1'b0;
  assign miso_s = spi_miso;
`endif

  // The done cycle is already spent in GAP, so it must not look ready yet.
  assign ready  = (state_q == StIdle) || ((state_q == StGap) && !done);
  assign accept = start && ready;
  assign hp_end = (hp_cnt_q == HpLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hp_cnt_q  <= '0;
      bit_cnt_q <= 3'd0;
      tx_sr_q   <= 8'h00;
      rx_sr_q   <= 8'h00;
      last_q    <= 1'b0;
      done      <= 1'b0;
      rx_data   <= 8'h00;
      spi_cs_n  <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StGap: begin
          if (accept) begin
            tx_sr_q  <= tx_data;
            last_q   <= last;
            spi_mosi <= tx_data[7];
            spi_cs_n <= 1'b0;
            hp_cnt_q <= '0;
            state_q  <= StLead;
          end
        end
        StLead: begin
          if (hp_end) begin
            hp_cnt_q  <= '0;
            bit_cnt_q <= 3'd0;
            spi_sck   <= 1'b1;
            if (!SampleOnFall) rx_sr_q <= {rx_sr_q[6:0], miso_s};
            state_q   <= StXfer;
          end else begin
            hp_cnt_q <= hp_cnt_q + 1'b1;
          end
        end
        StXfer: begin
          if (!hp_end) begin
            hp_cnt_q <= hp_cnt_q + 1'b1;
          end else begin
            hp_cnt_q <= '0;
            if (spi_sck) begin
              spi_sck <= 1'b0;
              if (SampleOnFall) rx_sr_q <= {rx_sr_q[6:0], miso_s};
              // After the 8th fall mosi keeps bit 0 rather than shifting in filler.
              if (bit_cnt_q != 3'd7) begin
                tx_sr_q  <= {tx_sr_q[6:0], 1'b0};
                spi_mosi <= tx_sr_q[6];
              end
            end else if (bit_cnt_q == 3'd7) begin
              done    <= 1'b1;
              rx_data <= rx_sr_q;
              state_q <= last_q ? StTrail : StGap;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              spi_sck   <= 1'b1;
              if (!SampleOnFall) rx_sr_q <= {rx_sr_q[6:0], miso_s};
            end
          end
        end
        StTrail: begin
          if (hp_end) begin
            hp_cnt_q <= '0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
            state_q  <= StIdle;
          end else begin
            hp_cnt_q <= hp_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
